// File: rtl/rv_pkg.sv
// RV32 definitions shared by the core's front end: ISA constants, fetch-stage
// state and output payload types, and PC helpers.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    // Major opcodes, bits [6:0] of the instruction word
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

    // Instruction slot presented to the decoder
    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_out_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: sequential +4 advance and redirect load with alignment.
// INSTR_FETCH_MISALIGN_TRAP_EN turns a misaligned redirect into a sticky fault.
module fetch_pc_reg
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic            fault
);

    logic [XLEN-1:0] target;

    assign target = word_align(redirect_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (advance) begin
            pc <= next_word(pc);
        end
    end

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    // Fault holds until the next redirect; an aligned one clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (redirect) begin
            fault <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, one instruction slot
// to the decoder, redirect with stale-response drop. Optional misaligned
// redirect fault via INSTR_FETCH_MISALIGN_TRAP_EN (see fetch_pc_reg).
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    output logic            out_imem_req,
    output logic [XLEN-1:0] out_imem_addr,
    input  logic            in_imem_ready,
    input  logic            in_imem_rvalid,
    input  logic [XLEN-1:0] in_imem_rdata,
    input  logic            in_redirect,
    input  logic [XLEN-1:0] in_redirect_pc,
    input  logic            in_stall,
    output logic            out_instr_valid,
    output logic [XLEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic            out_fetch_fault
);

    fetch_state_e    state;
    logic            drop;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic            fault;
    fetch_out_t      slot;
    logic            slot_free;
    logic            accept;
    logic            advance;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_fetch_pc_reg (
        .clk         (in_clk),
        .rst_n       (in_rst_n),
        .advance     (advance),
        .redirect    (in_redirect),
        .redirect_pc (in_redirect_pc),
        .pc          (fetch_pc),
        .fault       (fault)
    );

    // Request only when the slot will be free to take the response
    assign slot_free     = !out_instr_valid || !in_stall;
    assign out_imem_req  = (state == FETCH_REQ) && slot_free && !fault;
    assign out_imem_addr = fetch_pc;
    assign accept        = out_imem_req && in_imem_ready;
    assign advance       = (state == FETCH_WAIT) && in_imem_rvalid && !drop && !in_redirect;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state           <= FETCH_IDLE;
            drop            <= 1'b0;
            req_addr        <= RESET_PC;
            out_instr_valid <= 1'b0;
            slot            <= '{instruction: NOP_INSTR, pc: RESET_PC, pc_plus4: next_word(RESET_PC)};
        end else if (in_redirect) begin
            // A response still owed by memory belongs to the old path
            out_instr_valid <= 1'b0;
            if (accept || ((state == FETCH_WAIT) && !in_imem_rvalid)) begin
                drop  <= 1'b1;
                state <= FETCH_WAIT;
            end else begin
                drop  <= 1'b0;
                state <= FETCH_REQ;
            end
        end else begin
            if (out_instr_valid && !in_stall) begin
                out_instr_valid <= 1'b0;
            end
            case (state)
                FETCH_IDLE: state <= FETCH_REQ;
                FETCH_REQ: begin
                    if (accept) begin
                        state    <= FETCH_WAIT;
                        req_addr <= fetch_pc;
                    end
                end
                FETCH_WAIT: begin
                    if (in_imem_rvalid) begin
                        state <= FETCH_REQ;
                        if (drop) begin
                            drop <= 1'b0;
                        end else begin
                            out_instr_valid <= 1'b1;
                            slot <= '{instruction: in_imem_rdata, pc: req_addr,
                                      pc_plus4: next_word(req_addr)};
                        end
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    assign out_instruction = slot.instruction;
    assign out_pc          = slot.pc;
    assign out_pc_plus4    = slot.pc_plus4;
    assign out_fetch_fault = fault;

endmodule
